ak4619_tdm_port: RTL and testbench
==================================

AK4619_TDM_PORT -- requirements
Module: ak4619_tdm_port

Interface
REQ-001 Parameter W, default 16: sample width in bits, 1 <= W <= SLOT_W.
REQ-002 Parameter N_CH, default 4: channels per frame, one of 1, 2, 4, 8.
REQ-003 Parameter SLOT_W, default 32: BICK periods per channel slot, one of 16, 32.
REQ-004 Parameter DIV_LOG2, default 1: BICK half-period is 2^DIV_LOG2 clk cycles.
REQ-005 Port clk, input, 1: single clock; also the codec master clock.
REQ-006 Port rst, input, 1: asynchronous, active-high reset.
REQ-007 Port bick, output, 1: codec bit clock.
REQ-008 Port lrck, output, 1: codec frame clock.
REQ-009 Port sdin, output, 1: serial data to the codec DAC.
REQ-010 Port sdout, input, 1: serial data from the codec ADC.
REQ-011 Port dac_data, input, N_CH*W: channel c is bits [(c+1)*W-1 : c*W], two's complement.
REQ-012 Port dac_valid, input, 1: dac_data is offered this cycle.
REQ-013 Port dac_ready, output, 1: the hold buffer can accept a frame.
REQ-014 Port adc_data, output, N_CH*W: last captured frame, packed as dac_data.
REQ-015 Port adc_valid, output, 1: one-cycle pulse when adc_data updates.
REQ-016 Port frame_strobe, output, 1: one-cycle pulse at each frame start.
REQ-017 Port underrun, output, 1: sticky DAC underrun flag.
REQ-018 Port underrun_clr, input, 1: clears underrun.

Function
REQ-019 A free-running counter cnt of width DIV_LOG2+1+log2(SLOT_W)+log2(N_CH) SHALL increment every clk and wrap to 0; one frame = N_CH*SLOT_W*2^(DIV_LOG2+1) clk (512 at defaults).
REQ-020 bick SHALL equal cnt[DIV_LOG2]; lrck SHALL be high during the first half of the frame (inverted cnt MSB), giving 50 % duty.
REQ-021 Frame bit index = cnt[MSB:DIV_LOG2+1]; slot = index / SLOT_W; bit-in-slot = index mod SLOT_W.
REQ-022 sdin SHALL change only on the clk edge where bick falls (including the wrap edge), so it is stable at every bick rise.
REQ-023 In slot c, bits 0..W-1 of the slot SHALL carry channel c MSB-first with no bit delay; bits W..SLOT_W-1 SHALL drive 0.
REQ-024 sdout SHALL be sampled on the clk edge where bick rises; slot bits 0..W-1 form channel c MSB-first; bits >= W are ignored.
REQ-025 Handshake: dac_ready = !hold_full; a transfer occurs when dac_valid && dac_ready; the accepted word is written to the hold buffer and hold_full is set.
REQ-026 At the wrap edge, if hold_full: the frame shift buffer loads from the hold buffer and hold_full clears.
REQ-027 At the wrap edge, if hold empty and dac_valid: dac_data bypasses directly into the frame buffer; hold_full stays 0; this counts as the transfer.
REQ-028 At the wrap edge, if hold empty and !dac_valid: the frame buffer loads all zeros and underrun sets.
REQ-029 At the wrap edge, sdin SHALL present the MSB of channel 0 of the newly loaded frame.
REQ-030 At the wrap edge, adc_data SHALL load the frame just captured, and adc_valid and frame_strobe SHALL both be high for the cycle with cnt == 0.
REQ-031 underrun_clr clears underrun; if underrun_clr coincides with a new underrun event, set wins.
REQ-032 Latency: a word accepted during frame k is transmitted in frame k+1, or in frame k+1 itself when it bypasses at the k/k+1 wrap; an ADC sample in frame k appears on adc_data at the start of frame k+1.

Reset
REQ-033 While rst is high: cnt=0, bick=0, lrck=1, sdin=0, frame buffer=0, hold_full=0, dac_ready=1, adc_data=0, adc_valid=0, frame_strobe=0, underrun=0.
REQ-034 Reset asserted mid-frame SHALL abort the frame immediately; after release counting restarts at cnt=0 and no strobe is issued for the partial frame.
REQ-035 The first frame after reset SHALL transmit zeros and SHALL NOT flag underrun; its first wrap publishes adc_data normally.

Verification
REQ-036 Defaults; write dac_data = {16'h0004, 16'h0003, 16'h0002, 16'h8001} mid-frame 0 -> frame 1 sdin slot0 = 8001 MSB-first then 16 zeros; slot3 = 0004; dac_ready low until the wrap.
REQ-037 Codec model drives sdout slot1 = 16'hA5C3, others 0 in frame 0 -> at cnt==0, adc_valid=1 and adc_data[31:16] = 16'hA5C3, all other channels 0.
REQ-038 No write during frame 1 -> frame 2 sdin all zeros, underrun=1; pulse underrun_clr -> underrun=0; clr in the same cycle as a new underrun -> underrun stays 1.
REQ-039 dac_valid held high with hold empty exactly at the wrap edge -> bypass: the same frame transmits, dac_ready stays 1, no underrun.
REQ-040 Assert rst at cnt=200 for 3 cycles -> all outputs at reset values; next frame_strobe exactly 512 clk after release.
REQ-041 N_CH=8, SLOT_W=16, W=16, DIV_LOG2=0 -> frame = 256 clk, bick = clk/2, lrck high for 128 clk; 8-channel loopback sdin->sdout returns dac_data one frame later.

Source files
------------

// File: rtl/ak4619_tdm_port.sv
// TDM master port for the AK4619 codec: generates BICK/LRCK from clk,
// serialises one DAC frame per LRCK period and collects the ADC frame in parallel.
module ak4619_tdm_port #(
    parameter int W        = 16,
    parameter int N_CH     = 4,
    parameter int SLOT_W   = 32,
    parameter int DIV_LOG2 = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              bick,
    output logic              lrck,
    output logic              sdin,
    input  logic              sdout,
    input  logic [N_CH*W-1:0] dac_data,
    input  logic              dac_valid,
    output logic              dac_ready,
    output logic [N_CH*W-1:0] adc_data,
    output logic              adc_valid,
    output logic              frame_strobe,
    output logic              underrun,
    input  logic              underrun_clr
);

    localparam int CW = DIV_LOG2 + 1 + $clog2(SLOT_W) + $clog2(N_CH);
    localparam int FB = N_CH * SLOT_W;
    localparam int DW = N_CH * W;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          wrap;
    logic          bick_fall;
    logic          bick_rise;
    logic          hold_full;
    logic          hold_wr;
    logic [DW-1:0] hold_buf;
    logic [DW-1:0] next_frame;
    logic [FB-1:0] next_slots;
    logic [FB-1:0] tx_sr;
    logic [FB-1:0] rx_sr;

    // Places each channel MSB-first at the head of its slot; slot padding is zero.
    function automatic logic [FB-1:0] expand_frame(input logic [DW-1:0] f);
        logic [FB-1:0] s;
        s = '0;
        for (int c = 0; c < N_CH; c++)
            s[(N_CH-c)*SLOT_W-1 -: W] = f[c*W +: W];
        return s;
    endfunction

    function automatic logic [DW-1:0] collect_frame(input logic [FB-1:0] s);
        logic [DW-1:0] f;
        f = '0;
        for (int c = 0; c < N_CH; c++)
            f[c*W +: W] = s[(N_CH-c)*SLOT_W-1 -: W];
        return f;
    endfunction

    assign cnt_nx    = cnt + CW'(1);
    assign wrap      = &cnt;
    assign bick_fall = cnt[DIV_LOG2] & ~cnt_nx[DIV_LOG2];
    assign bick_rise = ~cnt[DIV_LOG2] & cnt_nx[DIV_LOG2];
    assign bick      = cnt[DIV_LOG2];
    assign lrck      = ~cnt[CW-1];
    assign dac_ready = ~hold_full;
    assign hold_wr   = dac_valid & ~hold_full & ~wrap;

    always_comb begin
        next_frame = '0;
        if (hold_full)
            next_frame = hold_buf;
        else if (dac_valid)
            next_frame = dac_data;
        next_slots = expand_frame(next_frame);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            tx_sr        <= '0;
            sdin         <= 1'b0;
            hold_full    <= 1'b0;
            adc_data     <= '0;
            adc_valid    <= 1'b0;
            frame_strobe <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            cnt          <= cnt_nx;
            adc_valid    <= wrap;
            frame_strobe <= wrap;
            if (wrap) begin
                tx_sr     <= next_slots;
                sdin      <= next_slots[FB-1];
                adc_data  <= collect_frame(rx_sr);
                hold_full <= 1'b0;
            end else begin
                if (bick_fall) begin
                    tx_sr <= tx_sr << 1;
                    sdin  <= tx_sr[FB-2];
                end
                if (hold_wr)
                    hold_full <= 1'b1;
            end
            // A fresh underrun outranks a simultaneous clear.
            if (wrap && !hold_full && !dac_valid)
                underrun <= 1'b1;
            else if (underrun_clr)
                underrun <= 1'b0;
        end
    end

    // Hold buffer and ADC shift register are fully rewritten before use.
    always_ff @(posedge clk) begin
        if (hold_wr)
            hold_buf <= dac_data;
        if (bick_rise)
            rx_sr <= {rx_sr[FB-2:0], sdout};
    end

endmodule

// File: tb/tb_ak4619_tdm_port.sv
// Directed bench for ak4619_tdm_port: default 4x32 configuration plus an 8x16 loopback instance.
module tb_ak4619_tdm_port;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default instance: 4 ch, 32-bit slots, BICK = clk/4, 512 clk frame
    logic         rst;
    logic         bick, lrck, sdin, sdout;
    logic [63:0]  dac_data;
    logic         dac_valid, dac_ready;
    logic [63:0]  adc_data;
    logic         adc_valid, frame_strobe, underrun, underrun_clr;

    // 8 ch, 16-bit slots, BICK = clk/2, 256 clk frame, sdin looped to sdout
    logic         rst8;
    logic         bick8, lrck8, sdin8;
    logic [127:0] dac_data8;
    logic         dac_valid8, dac_ready8;
    logic [127:0] adc_data8;
    logic         adc_valid8, frame_strobe8, underrun8;
    logic         underrun_clr8;

    ak4619_tdm_port dut (
        .clk(clk), .rst(rst), .bick(bick), .lrck(lrck), .sdin(sdin), .sdout(sdout),
        .dac_data(dac_data), .dac_valid(dac_valid), .dac_ready(dac_ready),
        .adc_data(adc_data), .adc_valid(adc_valid), .frame_strobe(frame_strobe),
        .underrun(underrun), .underrun_clr(underrun_clr)
    );

    ak4619_tdm_port #(.W(16), .N_CH(8), .SLOT_W(16), .DIV_LOG2(0)) dut8 (
        .clk(clk), .rst(rst8), .bick(bick8), .lrck(lrck8), .sdin(sdin8), .sdout(sdin8),
        .dac_data(dac_data8), .dac_valid(dac_valid8), .dac_ready(dac_ready8),
        .adc_data(adc_data8), .adc_valid(adc_valid8), .frame_strobe(frame_strobe8),
        .underrun(underrun8), .underrun_clr(underrun_clr8)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [127:0] sd_cap;
    logic [127:0] sdo_pat;

    localparam logic [63:0]  D1 = {16'h0004, 16'h0003, 16'h0002, 16'h8001};
    localparam logic [63:0]  D2 = {16'h1234, 16'hFFFF, 16'h0F0F, 16'hC001};
    localparam logic [127:0] D8 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    // ADC pattern with ones in the ignored slot padding
    localparam logic [127:0] PAT_MIX = {16'h8000, 16'hFFFF, 16'h0001, 16'hFFFF,
                                        16'h7FFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_bick"}, bick, 1'b0);
        check({tag, "_lrck"}, lrck, 1'b1);
        check({tag, "_sdin"}, sdin, 1'b0);
        check({tag, "_ready"}, dac_ready, 1'b1);
        check({tag, "_adc_data"}, adc_data, 64'h0);
        check({tag, "_adc_valid"}, adc_valid, 1'b0);
        check({tag, "_strobe"}, frame_strobe, 1'b0);
        check({tag, "_underrun"}, underrun, 1'b0);
    endtask

    // One default-config frame; loop index p equals the DUT counter value.
    task automatic run_frame(input int f);
        for (int p = 0; p < 512; p++) begin
            if (p % 4 == 2)
                sd_cap[7'(127 - p/4)] = sdin;
            case (f)
                0: begin
                    if (p == 0)   check("f0_no_strobe", frame_strobe, 1'b0);
                    if (p == 2)   check("f0_bick_hi", bick, 1'b1);
                    if (p == 4)   check("f0_bick_lo", bick, 1'b0);
                    if (p == 255) check("f0_lrck_hi", lrck, 1'b1);
                    if (p == 256) check("f0_lrck_lo", lrck, 1'b0);
                    if (p == 100) begin dac_data = D1; dac_valid = 1'b1; end
                    if (p == 101) begin dac_valid = 1'b0; check("f0_ready_after_wr", dac_ready, 1'b0); end
                    if (p == 511) check("f0_ready_before_wrap", dac_ready, 1'b0);
                end
                1: if (p == 1) check("f1_adc_valid_pulse", adc_valid, 1'b0);
                2: begin
                    if (p == 50)  underrun_clr = 1'b1;
                    if (p == 51)  begin underrun_clr = 1'b0; check("f2_underrun_clr", underrun, 1'b0); end
                    if (p == 511) underrun_clr = 1'b1;
                end
                3: begin
                    if (p == 0)   underrun_clr = 1'b0;
                    if (p == 100) underrun_clr = 1'b1;
                    if (p == 101) begin underrun_clr = 1'b0; check("f3_underrun_clr", underrun, 1'b0); end
                    if (p == 511) begin dac_data = D2; dac_valid = 1'b1; end
                end
                4: begin
                    if (p == 0) dac_valid = 1'b0;
                    if (p == 1) check("f4_ready_after_bypass", dac_ready, 1'b1);
                end
                default: ;
            endcase
            sdout = sdo_pat[7'(127 - p/4)];
            tick();
        end
    endtask

    initial begin
        int n;
        int k8, first8, lrck_hi, toggles;
        logic prev_bick;

        rst = 1'b1; rst8 = 1'b1;
        sdout = 1'b0; dac_data = '0; dac_valid = 1'b0; underrun_clr = 1'b0;
        dac_data8 = '0; dac_valid8 = 1'b0; underrun_clr8 = 1'b0;
        sd_cap = '0; sdo_pat = '0;
        repeat (3) tick();
        check_reset_state("rst0");
        rst = 1'b0;

        // frame 0: zeros out, word written mid-frame, codec sends A5C3 in slot 1
        sdo_pat = {32'h0, 16'hA5C3, 16'h0, 32'h0, 32'h0};
        run_frame(0);
        check("f0_sdin_zero", sd_cap, 128'h0);
        check("f0_adc_valid", adc_valid, 1'b1);
        check("f0_strobe", frame_strobe, 1'b1);
        check("f0_adc_data", adc_data, {16'h0, 16'h0, 16'hA5C3, 16'h0});
        check("f0_ready_after_wrap", dac_ready, 1'b1);
        check("f0_no_underrun", underrun, 1'b0);
        check("f0_sdin_msb", sdin, 1'b1);

        // frame 1: transmits D1, nothing written -> underrun at the next wrap
        sdo_pat = '0;
        run_frame(1);
        check("f1_sdin_frame", sd_cap, {16'h8001, 16'h0, 16'h0002, 16'h0,
                                        16'h0003, 16'h0, 16'h0004, 16'h0});
        check("f1_underrun", underrun, 1'b1);
        check("f1_adc_data", adc_data, 64'h0);

        // frame 2: zeros out; clear, then clear coinciding with a new underrun
        sdo_pat = PAT_MIX;
        run_frame(2);
        check("f2_sdin_zero", sd_cap, 128'h0);
        check("f2_underrun_set_wins", underrun, 1'b1);
        check("f2_adc_data", adc_data, {16'hFFFF, 16'h7FFF, 16'h0001, 16'h8000});

        // frame 3: bypass offered exactly at the wrap edge
        sdo_pat = '0;
        run_frame(3);
        check("f3_ready_bypass", dac_ready, 1'b1);
        check("f3_no_underrun", underrun, 1'b0);
        check("f3_sdin_msb", sdin, 1'b1);

        sdo_pat = PAT_MIX;
        run_frame(4);
        check("f4_sdin_bypass", sd_cap, {16'hC001, 16'h0, 16'h0F0F, 16'h0,
                                         16'hFFFF, 16'h0, 16'h1234, 16'h0});
        check("f4_adc_data", adc_data, {16'hFFFF, 16'h7FFF, 16'h0001, 16'h8000});

        // frame 5: fill the hold buffer, then reset at cnt 200
        sdo_pat = '0;
        for (int p = 0; p < 200; p++) begin
            dac_valid = (p == 150);
            dac_data  = D1;
            sdout     = 1'b0;
            tick();
        end
        dac_valid = 1'b0;
        check("f5_ready_before_rst", dac_ready, 1'b0);
        rst = 1'b1;
        #1;
        check_reset_state("rst_mid");
        repeat (3) tick();
        check_reset_state("rst_held");
        rst = 1'b0;

        n = 0;
        while (n < 600 && !frame_strobe) begin
            if (n == 511) check("rst_first_frame_no_underrun", underrun, 1'b0);
            tick();
            n++;
        end
        check("rst_strobe_delay", 32'(n), 32'd512);

        // 8-channel loopback instance
        rst8 = 1'b0;
        first8 = 0; lrck_hi = 0; toggles = 0; prev_bick = 1'b0;
        for (k8 = 1; k8 <= 512; k8++) begin
            tick();
            if (k8 <= 256) begin
                if (lrck8) lrck_hi++;
                if (bick8 != prev_bick) toggles++;
                prev_bick = bick8;
            end
            if (frame_strobe8 && first8 == 0) first8 = k8;
            if (k8 == 10) begin dac_data8 = D8; dac_valid8 = 1'b1; end
            if (k8 == 11) begin dac_valid8 = 1'b0; check("ch8_ready_after_wr", dac_ready8, 1'b0); end
            if (k8 == 256) check("ch8_adc_frame0", adc_data8, 128'h0);
            if (k8 == 512) begin
                check("ch8_adc_valid", adc_valid8, 1'b1);
                check("ch8_loopback", adc_data8, D8);
            end
        end
        check("ch8_frame_len", 32'(first8), 32'd256);
        check("ch8_lrck_high", 32'(lrck_hi), 32'd128);
        check("ch8_bick_toggles", 32'(toggles), 32'd256);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
